// File: rtl/iob_mem_arb_pkg.sv
// Shared definitions for the ext_mem data-side round-robin arbiter.
// Holds the FSM state encoding and the grant-index width helper.
package iob_mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  // Largest supported requester count
  localparam int N_MASTERS_MAX = 8;

  // Width of a master index, i.e. $clog2(N_MASTERS); kept at least 1 bit wide
  function automatic int grant_width(input int n_masters);
    return (n_masters > 1) ? $clog2(n_masters) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_picker.sv
// Combinational round-robin search. Starting one past rr_ptr and wrapping
// modulo N_MASTERS, returns the first asserted request index and whether
// any request is present. Holds no state; the pointer lives in the caller.
module iob_rr_picker #(
  parameter int N_MASTERS = 2,
  parameter int GRANT_W   = 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [GRANT_W-1:0]   rr_ptr,
  output logic [GRANT_W-1:0]   winner,
  output logic                 any
);

  // Scan rr_ptr+1 .. rr_ptr+N_MASTERS and keep the first hit
  always_comb begin
    int idx;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % N_MASTERS;
      if (!any && req[idx]) begin
        winner = GRANT_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_soc_opencryptolinux_mem_arbiter.sv
// Round-robin arbiter sharing one IOb-native ext_mem data port among
// N_MASTERS requesters. One transaction is outstanding at a time; the grant
// is held until the write is accepted or the read data returns.
// Optional per-master completion counters: define IOB_MEM_ARB_STATS_EN.
//
// Handshake: a master holds m_avalid_i with stable fields until its
// m_ready_o pulses. The arbiter latches the fields when it grants, so the
// slave side (s_avalid_o held until s_ready_i) sees a stable request even if
// the master misbehaves. Read data returns on m_rvalid_o[grant] one cycle
// pulse, mirroring s_rvalid_i while in RDWAIT.
module iob_soc_opencryptolinux_mem_arbiter
  import iob_mem_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic                          cke_i,
  input  logic [N_MASTERS-1:0]          m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          s_avalid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  input  logic [DATA_W-1:0]             s_rdata_i,
  output logic                          busy_o
`ifdef IOB_MEM_ARB_STATS_EN
  ,
  output logic [N_MASTERS*CNT_W-1:0]    grant_cnt_o,
  input  logic                          stats_clr_i
`endif
);

  localparam int GRANT_W = grant_width(N_MASTERS);
  localparam int STRB_W  = DATA_W / 8;

  arb_state_t           state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   rr_ptr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_any;

  iob_rr_picker #(
    .N_MASTERS (N_MASTERS),
    .GRANT_W   (GRANT_W)
  ) u_picker (
    .req    (m_avalid_i),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // FSM: grant and latch in IDLE, present in REQ, wait for read data in RDWAIT
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= GRANT_W'(N_MASTERS - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q  <= pick_idx;
            rr_ptr_q <= pick_idx;
            addr_q   <= m_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_q  <= m_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
            wstrb_q  <= m_wstrb_i[int'(pick_idx)*STRB_W +: STRB_W];
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (s_ready_i) state_q <= (wstrb_q == '0) ? RDWAIT : IDLE;
        end
        RDWAIT: begin
          if (s_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Route slave handshakes back to the granted master only
  always_comb begin
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q == GRANT_W'(k)) begin
        m_ready_o[k]  = (state_q == REQ) && s_ready_i;
        m_rvalid_o[k] = (state_q == RDWAIT) && s_rvalid_i;
      end
    end
    if ((state_q == RDWAIT) && s_rvalid_i) m_rdata_o = s_rdata_i;
  end

  assign s_avalid_o = (state_q == REQ);
  assign s_addr_o   = s_avalid_o ? addr_q  : '0;
  assign s_wdata_o  = s_avalid_o ? wdata_q : '0;
  assign s_wstrb_o  = s_avalid_o ? wstrb_q : '0;
  assign busy_o     = (state_q != IDLE);

`ifdef IOB_MEM_ARB_STATS_EN
  logic                 done;
  logic [CNT_W-1:0]     cnt_q [N_MASTERS];

  assign done = ((state_q == REQ) && s_ready_i && (wstrb_q != '0)) ||
                ((state_q == RDWAIT) && s_rvalid_i);

  // Saturating per-master completion counters; clear beats increment
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_MASTERS; k++) cnt_q[k] <= '0;
    end else if (cke_i) begin
      if (stats_clr_i) begin
        for (int k = 0; k < N_MASTERS; k++) cnt_q[k] <= '0;
      end else if (done) begin
        for (int k = 0; k < N_MASTERS; k++) begin
          if ((grant_q == GRANT_W'(k)) && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Flatten counters onto the output bus, master k at [k*CNT_W +: CNT_W]
  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < N_MASTERS; k++) grant_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end
`endif

`ifndef SYNTHESIS
  // Flag a slave response arriving when no read is waiting for it
  a_rvalid_only_in_rdwait : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    s_rvalid_i |-> (state_q == RDWAIT))
    else $error("mem_arbiter: s_rvalid_i seen outside RDWAIT");
`endif

endmodule
